// File: rtl/gf180mcu_osu_sc_12t_and2_pipe.sv
// DEPTH-stage valid/ready pipeline of WIDTH bitwise AND (NAND when INVERT=1) lanes.
// Defining GF180MCU_OSU_SC_SCAN_EN adds a scan chain (SE/SI/SO) through the output register.
module gf180mcu_osu_sc_12t_and2_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned INVERT = 0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             VI,
    output logic             RO,
    output logic [WIDTH-1:0] Y,
    output logic             VO,
    input  logic             RI
`ifdef GF180MCU_OSU_SC_SCAN_EN
    ,
    input  logic             SE,
    input  logic             SI,
    output logic             SO
`endif
);

    localparam int unsigned LAST = DEPTH - 1;

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0]            lane_res;
    logic [WIDTH-1:0]            shift_vec;
    logic                        scan_en;
    logic                        scan_in;
    logic                        in_fire;

`ifdef GF180MCU_OSU_SC_SCAN_EN
    assign scan_en = SE;
    assign scan_in = SI;
    assign SO      = data_q[LAST][WIDTH-1];
`else
    assign scan_en = 1'b0;
    assign scan_in = 1'b0;
`endif

    if (WIDTH > 1) begin : g_shift_wide
        assign shift_vec = {data_q[LAST][WIDTH-2:0], scan_in};
    end else begin : g_shift_narrow
        assign shift_vec = scan_in;
    end

    assign lane_res = (INVERT != 0) ? ~(A & B) : (A & B);

    // Stage k can take a word when some stage at or beyond k is empty or the sink is
    // draining; scan mode freezes the whole pipe.
    always_comb begin
        adv = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            adv[k] = !scan_en && (RI || ((~valid_q >> k) != '0));
        end
    end

    assign in_fire = VI && adv[0];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (adv[k]) begin
                if (k == 0) begin
                    valid_d[0] = in_fire;
                    if (in_fire) data_d[0] = lane_res;
                end else begin
                    valid_d[k] = valid_q[k-1];
                    if (valid_q[k-1]) data_d[k] = data_q[k-1];
                end
            end
        end
        if (scan_en) data_d[LAST] = shift_vec;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Ready is held low for the whole time reset is asserted.
    assign RO = RN && adv[0];
    assign Y  = data_q[LAST];
    assign VO = valid_q[LAST];

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_and2_pipe.sv
// Self-checking bench for gf180mcu_osu_sc_12t_and2_pipe: AND and NAND instances
// compared against a FIFO/occupancy reference model.
module tb_gf180mcu_osu_sc_12t_and2_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;

    logic             CLK = 1'b0;
    logic             RN;
    logic [WIDTH-1:0] A, B;
    logic             VI, RI;
    logic             RO, VO;
    logic [WIDTH-1:0] Y;
    logic             ro_n, vo_n;
    logic [WIDTH-1:0] y_n;
`ifdef GF180MCU_OSU_SC_SCAN_EN
    logic             SE, SI, SO, so_n;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: accepted operands in order plus the edge index of each acceptance.
    logic [WIDTH-1:0] q_a[$];
    logic [WIDTH-1:0] q_b[$];
    int               q_e[$];
    int               edges = 0;

    always #5 CLK = ~CLK;

    gf180mcu_osu_sc_12t_and2_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INVERT(0)) u_and (
        .CLK(CLK), .RN(RN), .A(A), .B(B), .VI(VI), .RO(RO), .Y(Y), .VO(VO), .RI(RI)
`ifdef GF180MCU_OSU_SC_SCAN_EN
        , .SE(SE), .SI(SI), .SO(SO)
`endif
    );

    gf180mcu_osu_sc_12t_and2_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INVERT(1)) u_nand (
        .CLK(CLK), .RN(RN), .A(A), .B(B), .VI(VI), .RO(ro_n), .Y(y_n), .VO(vo_n), .RI(RI)
`ifdef GF180MCU_OSU_SC_SCAN_EN
        , .SE(SE), .SI(SI), .SO(so_n)
`endif
    );

    // Ready drops only when every stage holds a word and the sink is stalled.
    function automatic bit exp_ro();
        return RN && !(q_e.size() == int'(DEPTH) && !RI);
    endfunction

    // The oldest word reaches the last stage DEPTH-1 edges after it was accepted.
    function automatic bit exp_vo();
        return q_e.size() > 0 && (edges - q_e[0] >= int'(DEPTH) - 1);
    endfunction

    task automatic set_in(input bit vi, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit ri);
        VI = vi;
        A  = a;
        B  = b;
        RI = ri;
        #1;
    endtask

    task automatic tick();
        bit pop, push;
        pop  = exp_vo() && RI;
        push = VI && exp_ro();
        @(posedge CLK);
        edges++;
        if (pop) begin
            void'(q_a.pop_front());
            void'(q_b.pop_front());
            void'(q_e.pop_front());
        end
        if (push) begin
            q_a.push_back(A);
            q_b.push_back(B);
            q_e.push_back(edges);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RN = 1'b0;
        #1;
        total++; if (Y !== '0) begin bad++; $display("FAIL reset_y: got %h want 00", Y); end
        total++; if (VO !== 1'b0) begin bad++; $display("FAIL reset_vo: got %b want 0", VO); end
        total++; if (RO !== 1'b0) begin bad++; $display("FAIL reset_ro: got %b want 0", RO); end
        total++; if (y_n !== '0) begin bad++; $display("FAIL reset_y_nand: got %h want 00", y_n); end
        @(negedge CLK);
        set_in(1'b1, 8'hAA, 8'hFF, 1'b1);
        total++; if (RO !== 1'b0) begin bad++; $display("FAIL reset_ro_held: got %b want 0", RO); end
        tick();
        RN = 1'b1;
        set_in(1'b0, '0, '0, 1'b1);
        total++; if (RO !== 1'b1) begin bad++; $display("FAIL reset_release_ro: got %b want 1", RO); end
        total++; if (VO !== 1'b0) begin bad++; $display("FAIL reset_release_vo: got %b want 0", VO); end
        tick();
    endtask

    task automatic test_basic();
        set_in(1'b1, 8'hF0, 8'h3C, 1'b1);
        total++; if (RO !== 1'b1) begin bad++; $display("FAIL basic_ro: got %b want 1", RO); end
        tick();
        for (int c = 1; c <= 4; c++) begin
            set_in(1'b0, '0, '0, 1'b1);
            total++;
            if (VO !== (c == 2)) begin
                bad++; $display("FAIL basic_vo cyc=%0d: got %b want %b", c, VO, (c == 2));
            end
            if (c == 2) begin
                total++; if (Y !== 8'h30) begin bad++; $display("FAIL basic_y: got %h want 30", Y); end
            end
            tick();
        end
    endtask

    task automatic test_invert();
        set_in(1'b1, 8'hFF, 8'h0F, 1'b1);
        tick();
        for (int c = 1; c <= 3; c++) begin
            set_in(1'b0, '0, '0, 1'b1);
            total++;
            if (vo_n !== (c == 2)) begin
                bad++; $display("FAIL invert_vo cyc=%0d: got %b want %b", c, vo_n, (c == 2));
            end
            if (c == 2) begin
                total++; if (y_n !== 8'hF0) begin bad++; $display("FAIL invert_y: got %h want f0", y_n); end
                total++; if (Y !== 8'h0F) begin bad++; $display("FAIL invert_and_y: got %h want 0f", Y); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] words [3];
        int got;
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        for (int c = 0; c < 2; c++) begin
            set_in(1'b1, words[c], 8'hFF, 1'b0);
            total++; if (RO !== 1'b1) begin bad++; $display("FAIL bp_ro_accept%0d: got %b want 1", c, RO); end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, words[2], 8'hFF, 1'b0);
            total++; if (RO !== 1'b0) begin bad++; $display("FAIL bp_ro_full: got %b want 0", RO); end
            total++;
            if (VO !== 1'b1 || Y !== 8'h01) begin
                bad++; $display("FAIL bp_hold: got vo=%b y=%h want vo=1 y=01", VO, Y);
            end
            tick();
        end
        got = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) set_in(1'b1, words[2], 8'hFF, 1'b1);
            else        set_in(1'b0, '0, '0, 1'b1);
            if (c == 0) begin
                total++; if (RO !== 1'b1) begin bad++; $display("FAIL bp_ro_rise: got %b want 1", RO); end
            end
            if (VO === 1'b1) begin
                total++;
                if (got >= 3) begin
                    bad++; $display("FAIL bp_extra: got y=%h want no more words", Y);
                end else if (Y !== words[got]) begin
                    bad++; $display("FAIL bp_order%0d: got %h want %h", got, Y, words[got]);
                end
                got++;
            end
            tick();
        end
        total++; if (got != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", got); end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] ea [16];
        logic [WIDTH-1:0] eb [16];
        bit want_vo;
        for (int i = 0; i < 16; i++) begin
            ea[i] = WIDTH'($urandom);
            eb[i] = WIDTH'($urandom);
        end
        for (int c = 0; c < 22; c++) begin
            if (c < 16) set_in(1'b1, ea[c], eb[c], 1'b1);
            else        set_in(1'b0, '0, '0, 1'b1);
            want_vo = (c >= int'(DEPTH)) && (c < 16 + int'(DEPTH));
            total++;
            if (VO !== want_vo) begin
                bad++; $display("FAIL stream_vo cyc=%0d: got %b want %b", c, VO, want_vo);
            end
            if (want_vo) begin
                total++;
                if (Y !== (ea[c-DEPTH] & eb[c-DEPTH])) begin
                    bad++;
                    $display("FAIL stream_y cyc=%0d: got %h want %h", c, Y, ea[c-DEPTH] & eb[c-DEPTH]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ey;
        for (int c = 0; c < 400; c++) begin
            set_in(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom),
                   $urandom_range(0, 3) != 0);
            total++;
            if (RO !== exp_ro()) begin
                bad++; $display("FAIL rand_ro cyc=%0d: got %b want %b", c, RO, exp_ro());
            end
            total++;
            if (VO !== exp_vo() || vo_n !== exp_vo()) begin
                bad++; $display("FAIL rand_vo cyc=%0d: got %b/%b want %b", c, VO, vo_n, exp_vo());
            end
            if (exp_vo()) begin
                ey = q_a[0] & q_b[0];
                total++;
                if (Y !== ey || y_n !== ~ey) begin
                    bad++; $display("FAIL rand_y cyc=%0d: got %h/%h want %h/%h", c, Y, y_n, ey, ~ey);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < int'(DEPTH) + 2; c++) begin
            set_in(1'b0, '0, '0, 1'b1);
            tick();
        end
        set_in(1'b1, 8'h11, 8'hFF, 1'b1);
        tick();
        set_in(1'b1, 8'h22, 8'hFF, 1'b1);
        tick();
        set_in(1'b0, '0, '0, 1'b1);
        RN = 1'b0;
        #1;
        total++;
        if (Y !== '0 || VO !== 1'b0 || RO !== 1'b0) begin
            bad++; $display("FAIL midreset_now: got y=%h vo=%b ro=%b want 00/0/0", Y, VO, RO);
        end
        q_a.delete(); q_b.delete(); q_e.delete();
        RN = 1'b1;
        #1;
        total++; if (RO !== 1'b1) begin bad++; $display("FAIL midreset_ro: got %b want 1", RO); end
        for (int c = 0; c < 4; c++) begin
            tick();
            set_in(1'b0, '0, '0, 1'b1);
            total++;
            if (VO !== 1'b0) begin bad++; $display("FAIL midreset_stale cyc=%0d: got %b want 0", c, VO); end
        end
    endtask

`ifdef GF180MCU_OSU_SC_SCAN_EN
    task automatic test_scan();
        logic [7:0] pat;
        logic [7:0] sh;
        pat = 8'h4D;
        sh  = Y;
        SE  = 1'b1;
        // Feed MSB first so the pattern read from bit 0 upward ends in Y.
        for (int i = 0; i < 8; i++) begin
            SI = pat[7-i];
            set_in(1'b0, '0, '0, 1'b1);
            total++;
            if (SO !== sh[7] || so_n !== sh[7]) begin
                bad++; $display("FAIL scan_so step=%0d: got %b/%b want %b", i, SO, so_n, sh[7]);
            end
            total++; if (RO !== 1'b0) begin bad++; $display("FAIL scan_ro: got %b want 0", RO); end
            tick();
            sh = {sh[6:0], pat[7-i]};
        end
        total++; if (Y !== 8'h4D) begin bad++; $display("FAIL scan_y: got %h want 4d", Y); end
        total++; if (VO !== 1'b0) begin bad++; $display("FAIL scan_vo: got %b want 0", VO); end
        total++; if (SO !== 1'b0) begin bad++; $display("FAIL scan_so_final: got %b want 0", SO); end
        SE = 1'b0;
    endtask
`endif

    initial begin
        RN = 1'b1;
        VI = 1'b0;
        A  = '0;
        B  = '0;
        RI = 1'b1;
`ifdef GF180MCU_OSU_SC_SCAN_EN
        SE = 1'b0;
        SI = 1'b0;
`endif
        test_reset();
        test_basic();
        test_invert();
        test_backpressure();
        test_stream();
        test_random();
        test_reset_midflight();
`ifdef GF180MCU_OSU_SC_SCAN_EN
        test_scan();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
